// File: rtl/serial_program_loader.sv
// Byte-stream program loader: receives a framed image (16-bit LE word count, LE payload words,
// XOR checksum) and writes each assembled word to consecutive RAM addresses.
//
// state   | meaning
// IDLE    | waiting for start after reset
// HDR_LO  | expecting word count bits [7:0]
// HDR_HI  | expecting word count bits [15:8]
// DATA_LO | expecting low byte of the next payload word
// DATA_HI | expecting high byte of the next payload word
// WRITE   | one-cycle RAM write strobe
// CHECK   | expecting the checksum byte
// DONE    | image loaded with a good checksum, waiting for start
// ERROR   | oversize header or bad checksum, waiting for start
module serial_program_loader #(
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    MAX_WORDS  = 256
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [7:0]            i_in_data,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_write,
    output logic [15:0]           o_mem_write_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error,
    output logic [15:0]           o_words_loaded
);

    typedef enum logic [3:0] {
        S_IDLE, S_HDR_LO, S_HDR_HI, S_DATA_LO, S_DATA_HI, S_WRITE, S_CHECK, S_DONE, S_ERROR
    } state_t;

    state_t                r_state;
    logic                  r_in_ready;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic                  r_mem_write;
    logic [15:0]           r_mem_write_data;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_error;
    logic [15:0]           r_words_loaded;
    logic [15:0]           r_count;
    logic [15:0]           r_index;
    logic [7:0]            r_checksum;
    logic [7:0]            r_lo;

    logic                  w_xfer;
    logic [15:0]           w_hdr_count;
    logic [15:0]           w_index_next;
    logic [ADDR_WIDTH-1:0] w_write_addr;

    assign w_xfer       = i_in_valid && r_in_ready;
    assign w_hdr_count  = {i_in_data, r_count[7:0]};
    assign w_index_next = r_index + 16'd1;
    assign w_write_addr = BASE_ADDR + ADDR_WIDTH'(r_index);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state          <= S_IDLE;
            r_in_ready       <= 1'b0;
            r_mem_addr       <= BASE_ADDR;
            r_mem_write      <= 1'b0;
            r_mem_write_data <= 16'd0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_error          <= 1'b0;
            r_words_loaded   <= 16'd0;
            r_count          <= 16'd0;
            r_index          <= 16'd0;
            r_checksum       <= 8'd0;
            r_lo             <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (i_start) begin
                        r_state        <= S_HDR_LO;
                        r_in_ready     <= 1'b1;
                        r_busy         <= 1'b1;
                        r_done         <= 1'b0;
                        r_error        <= 1'b0;
                        r_words_loaded <= 16'd0;
                        r_checksum     <= 8'd0;
                        r_index        <= 16'd0;
                    end
                end
                S_HDR_LO: begin
                    if (w_xfer) begin
                        r_count[7:0] <= i_in_data;
                        r_state      <= S_HDR_HI;
                    end
                end
                S_HDR_HI: begin
                    if (w_xfer) begin
                        r_count[15:8] <= i_in_data;
                        if (w_hdr_count == 16'd0) begin
                            r_state <= S_CHECK;
                        end else if ({16'd0, w_hdr_count} > $unsigned(MAX_WORDS)) begin
                            r_state    <= S_ERROR;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b0;
                            r_error    <= 1'b1;
                        end else begin
                            r_state <= S_DATA_LO;
                        end
                    end
                end
                S_DATA_LO: begin
                    if (w_xfer) begin
                        r_lo       <= i_in_data;
                        r_checksum <= r_checksum ^ i_in_data;
                        r_state    <= S_DATA_HI;
                    end
                end
                S_DATA_HI: begin
                    // address and data are captured here so they hold steady after the strobe
                    if (w_xfer) begin
                        r_checksum       <= r_checksum ^ i_in_data;
                        r_mem_write_data <= {i_in_data, r_lo};
                        r_mem_addr       <= w_write_addr;
                        r_mem_write      <= 1'b1;
                        r_in_ready       <= 1'b0;
                        r_state          <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_mem_write    <= 1'b0;
                    r_in_ready     <= 1'b1;
                    r_index        <= w_index_next;
                    r_words_loaded <= r_words_loaded + 16'd1;
                    r_state        <= (w_index_next == r_count) ? S_CHECK : S_DATA_LO;
                end
                S_CHECK: begin
                    if (w_xfer) begin
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b0;
                        if (i_in_data == r_checksum) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_error <= 1'b1;
                            r_state <= S_ERROR;
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b0;
                    r_mem_write <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign o_in_ready       = r_in_ready;
    assign o_mem_addr       = r_mem_addr;
    assign o_mem_write      = r_mem_write;
    assign o_mem_write_data = r_mem_write_data;
    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_error          = r_error;
    assign o_words_loaded   = r_words_loaded;

endmodule
